division_seq: RTL and testbench
===============================

# division_seq

Parametrised multi-cycle integer divider for the CPU execute stage, successor to the single-cycle combinational divider. Computes quotient and remainder of an N-bit dividend by an N-bit divisor with a radix-2 restoring algorithm, one quotient bit per clock. Supports optional signed operation and explicit divide-by-zero and overflow handling. Uses a start/busy/done handshake so the pipeline stalls while a division is in flight. Produces the same N/Z/C/V flag nibble as the other ALU units.

## Interface
- `N`, default 32: operand, quotient and remainder width (≥ 2).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a division; sampled only when `busy`=0.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned.
- `a`  in  N  dividend.
- `b`  in  N  divisor.
- `busy`  out  1  division in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse when results become valid.
- `quotient`  out  N  result; held until the next `done`.
- `remainder`  out  N  result; held until the next `done`.
- `banderas`  out  4  [3]=N, [2]=Z, [1]=C, [0]=V; held with the results.
- `div_zero`  out  1  last completed operation had `b`=0; held with the results.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE with `start`=1 latches `a`, `b` and `signed_mode`.
  - If `b`=0: go to FINISH and mark divide-by-zero.
  - If signed, `a`=MIN (1 followed by N−1 zeros) and `b`=all ones: go to FINISH and mark overflow.
  - Otherwise load the magnitudes, clear the partial remainder and go to RUN.
- RUN iteration: shift {rem, dividend} left 1, trial-subtract the divisor magnitude (N+1-bit subtraction), keep the result if non-negative, and set the quotient LSB accordingly.
- An internal counter counts N iterations, then the block moves to FINISH.
- FINISH, normal case:
  - Quotient is negated if signed and sign(a)≠sign(b).
  - Remainder is negated if signed and `a` was negative, so the remainder takes the dividend's sign.
- FINISH, divide-by-zero: `quotient`=all ones, `remainder`=`a`, `div_zero`=1, V=1.
- FINISH, overflow: `quotient`=MIN, `remainder`=0, V=1.
- Flags:
  - N = `quotient[N-1]` in signed mode, else 0.
  - Z = (`quotient`==0).
  - C = 0.
  - V as defined above, else 0.
- FINISH registers the outputs, pulses `done` and returns to IDLE.
- `start` while `busy`=1 has no effect; there is no queueing.
- `start` in the cycle `done`=1 is legal, because the block is back in IDLE.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `banderas`=0, `div_zero`=0. The in-flight operation is discarded and no `done` is produced.
- Timing is counted from edge k, the edge at which `start` is sampled in IDLE:
  - Normal operation: `busy`=1 from edge k to edge k+N+1. Results, flags and `done` become valid after edge k+N+1. Latency is N+1 cycles.
  - Divide-by-zero or overflow: `busy`=1 for one cycle. Results and `done` become valid after edge k+1. Latency is 1 cycle.
- `done` is high for exactly one cycle. `busy` and `done` are never high together.
- Operand inputs may change freely after edge k.

## Configuration
- `DIVISION_SIGNED_EN` defined:
  - `signed_mode` is honoured.
  - Sign-correction logic and overflow detection are compiled in.
- Not defined:
  - `signed_mode` is ignored and every operation is unsigned.
  - The overflow path is absent, N flag is always 0, and V is set only on divide-by-zero.
  - The port list is unchanged.

## Structure
- Package `division_pkg`:
  - State enum `div_state_t` (IDLE, RUN, FINISH).
  - Flag index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- Sub-module `division_step`: combinational single-iteration restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- Top level holds the FSM, counter, operand registers and sign/flag logic.

## Test plan
1. N=8, unsigned, a=100, b=7 → after 9 cycles: q=14, r=2, `banderas`=0000, `done` pulses once.
2. N=8, signed (macro defined), a=−100 (0x9C), b=7 → q=−14 (0xF2), r=−2 (0xFE), N=1.
3. N=8, b=0, a=0x55 → after 1 cycle: q=0xFF, r=0x55, `div_zero`=1, V=1.
4. N=8, signed, a=0x80, b=0xFF → after 1 cycle: q=0x80, r=0, V=1. Without the macro, the same inputs give q=0, r=0x80, Z=1 after 9 cycles.
5. Assert `start` again 3 cycles after the first start → ignored; only one `done`; results match the first operands.
6. Assert `rst` at cycle 4 of RUN → all outputs 0 immediately, no `done`. The next start, a=9, b=3, gives q=3, r=0.

Source files
------------

// File: rtl/division_pkg.sv
// division_pkg -- shared types and constants for the sequential divider.
//   div_state_t : FSM states (IDLE, RUN, FINISH)
//   FLAG_*      : bit positions inside the 4-bit N/Z/C/V flag nibble
package division_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/division_step.sv
// division_step -- one combinational iteration of radix-2 restoring division.
//   i_rem : partial remainder (always < i_div on entry)
//   i_bit : next dividend bit shifted into the remainder
//   i_div : divisor magnitude
//   o_rem : updated partial remainder
//   o_q   : quotient bit produced by this iteration
module division_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_div,
  output logic [N-1:0] o_rem,
  output logic         o_q
);

  logic [N:0]   w_shift;
  logic [N-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // Trial subtraction is decided on the full N+1-bit shifted value. When it
  // succeeds the true difference is below the divisor, so the low N bits of
  // the modular difference are exact.
  assign o_q    = (w_shift >= {1'b0, i_div});
  assign w_diff = w_shift[N-1:0] - i_div;
  assign o_rem  = o_q ? w_diff : w_shift[N-1:0];

endmodule

// File: rtl/division_seq.sv
// division_seq -- multi-cycle N-bit integer divider, one quotient bit per clock.
// Optional macro: DIVISION_SIGNED_EN enables signed operation (signed_mode,
// sign correction and MIN / -1 overflow detection). Without it every
// operation is unsigned and signed_mode is ignored.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : request a division (sampled only while idle)
//   signed_mode       : 1 = two's-complement operands
//   a, b              : dividend, divisor
//   busy              : division in flight, start ignored
//   done              : one-cycle pulse, results valid
//   quotient/remainder: results, held until the next done
//   banderas          : {N, Z, C, V} flags, held with the results
//   div_zero          : last completed operation had b = 0
module division_seq
  import division_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic [3:0]   banderas,
  output logic         div_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN  = {1'b1, {(N-1){1'b0}}};

`ifdef DIVISION_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + N'(1)) : v;
  endfunction

  div_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [N-1:0]  r_quot, r_rem_out;
  logic [3:0]    r_flags;
  logic          r_dz_out;

  logic [N-1:0]  r_a, r_dvd, r_dvs, r_rem;
  logic          r_neg_q, r_neg_r, r_sm, r_dz, r_ov;

  logic          w_sm, w_a_neg, w_b_neg, w_bzero, w_ovf, w_qbit;
  logic [N-1:0]  w_a_mag, w_b_mag, w_rem_nxt, w_q_fin, w_r_fin;
  logic [3:0]    w_flags;
  logic          w_accept;

  // Operand decode: magnitudes and special cases seen at the start edge.
  assign w_sm     = signed_mode & SIGNED_EN;
  assign w_a_neg  = w_sm & a[N-1];
  assign w_b_neg  = w_sm & b[N-1];
  assign w_a_mag  = cond_neg(a, w_a_neg);
  assign w_b_mag  = cond_neg(b, w_b_neg);
  assign w_bzero  = (b == '0);
`ifdef DIVISION_SIGNED_EN
  assign w_ovf    = w_sm & (a == MIN) & (b == '1) & ~w_bzero;
`else
  assign w_ovf    = 1'b0;
`endif
  assign w_accept = (r_state == IDLE) & start;

  division_step #(.N(N)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[N-1]),
    .i_div (r_dvs),
    .o_rem (w_rem_nxt),
    .o_q   (w_qbit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (w_bzero | w_ovf) ? FINISH : RUN;
      RUN:     if (r_cnt == LAST) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == RUN) ? r_cnt + CW'(1) : '0;
    end
  end

  // Iteration datapath: the dividend register shifts left and collects the
  // quotient bits from the bottom, so it holds the quotient magnitude at the end.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= a;
      r_dvd   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_rem   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_sm    <= w_sm;
      r_dz    <= w_bzero;
      r_ov    <= w_ovf;
    end else if (r_state == RUN) begin
      r_rem   <= w_rem_nxt;
      r_dvd   <= {r_dvd[N-2:0], w_qbit};
    end
  end

  // Result selection and flags for the FINISH cycle.
  always_comb begin
    w_q_fin = cond_neg(r_dvd, r_neg_q);
    w_r_fin = cond_neg(r_rem, r_neg_r);
    if (r_dz) begin
      w_q_fin = '1;
      w_r_fin = r_a;
    end else if (r_ov) begin
      w_q_fin = MIN;
      w_r_fin = '0;
    end
    w_flags         = '0;
    w_flags[FLAG_N] = r_sm & w_q_fin[N-1];
    w_flags[FLAG_Z] = (w_q_fin == '0);
    w_flags[FLAG_C] = 1'b0;
    w_flags[FLAG_V] = r_dz | r_ov;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_flags   <= '0;
      r_dz_out  <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      if (r_state == FINISH) begin
        r_quot    <= w_q_fin;
        r_rem_out <= w_r_fin;
        r_flags   <= w_flags;
        r_dz_out  <= r_dz;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_rem_out;
  assign banderas  = r_flags;
  assign div_zero  = r_dz_out;

endmodule

// File: tb/tb_division_seq.sv
module tb_division_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sm;
  logic [N-1:0] ia, ib;
  logic         busy, done, div_zero;
  logic [N-1:0] quotient, remainder;
  logic [3:0]   banderas;

  division_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (sm),
    .a           (ia),
    .b           (ib),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .banderas    (banderas),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [3:0]   f;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    exp_t e;
    logic sme, v;
    int   sa, sb_i, lat;
`ifdef DIVISION_SIGNED_EN
    sme = s;
`else
    sme = 1'b0;
`endif
    e.dz = 1'b0;
    v    = 1'b0;
    lat  = N + 1;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; v = 1'b1; lat = 1;
    end else if (sme && a == 8'h80 && b == 8'hFF) begin
      e.q = 8'h80; e.r = '0; v = 1'b1; lat = 1;
    end else if (sme) begin
      sa   = $signed(a);
      sb_i = $signed(b);
      e.q  = 8'(sa / sb_i);
      e.r  = 8'(sa % sb_i);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.f   = {sme & e.q[N-1], (e.q == 0), 1'b0, v};
    e.cyc = cyc + 1 + lat;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      chk("busy_with_done", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient",  32'(quotient),  32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("banderas",  32'(banderas),  32'(e.f));
        chk("div_zero",  32'(div_zero),  32'(e.dz));
        chk("latency",   32'(cyc),       32'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    wait_idle();
    start = 1'b1; ia = a; ib = b; sm = s;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    ia = 8'($urandom); ib = 8'($urandom); sm = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_q"},    32'(quotient), 32'd0);
    chk({tag, "_r"},    32'(remainder), 32'd0);
    chk({tag, "_flags"},32'(banderas), 32'd0);
    chk({tag, "_dz"},   32'(div_zero), 32'd0);
  endtask

  initial begin
    int k;
    logic [N-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; sm = 1'b0; ia = '0; ib = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    drive(8'd100, 8'd7, 1'b0);
    drive(8'h9C, 8'd7, 1'b1);
    drive(8'h55, 8'd0, 1'b0);
    drive(8'h80, 8'hFF, 1'b1);
    drive(8'h80, 8'hFF, 1'b0);
    drive(8'hFF, 8'd1, 1'b0);
    drive(8'hFF, 8'hFF, 1'b1);
    drive(8'h7F, 8'h80, 1'b1);
    drive(8'd0, 8'd5, 1'b1);
    drive(8'h55, 8'd0, 1'b1);
    drive(8'd7, 8'hF9, 1'b1);
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      drive(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Second start while busy is ignored.
    drive(8'd200, 8'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; ia = 8'd50; ib = 8'd5; sm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (N + 4) @(negedge clk);

    // Reset in the middle of RUN discards the operation.
    drive(8'd200, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrun_reset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(8'd9, 8'd3, 1'b0);

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (N + 4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
